axi_tdd_ng_sync_ctrl: RTL and testbench
=======================================

// Module: axi_tdd_ng_sync_ctrl
// PURPOSE
// - Sequencer/configurator in front of the TDD-NG frame counter. Merges external, internal-periodic
//   and software sync sources into one tdd_sync pulse, and counts delivered syncs.
// - Flags syncs that arrive while the counter is not ARMED.
// - Shadows timing config (burst count, startup delay, frame length) and commits it only when the
//   counter is IDLE/ARMED, so a running frame never sees a mid-frame change.
// PARAMETERS
// - REGISTER_WIDTH     32  width of startup delay / frame length
// - BURST_COUNT_WIDTH  32  width of burst count
// - SYNC_PERIOD_WIDTH  32  width of internal sync period and sync_count
// PORTS
// - clk                  in   1    clock
// - resetn               in   1    reset, synchronous, active-low
// - tdd_enable           in   1    global enable; 0 flushes generator state
// - tdd_cstate           in   state_t  counter state (IDLE/ARMED/WAITING/RUNNING)
// - sync_ext_en          in   1    accept external sync
// - sync_int_en          in   1    enable internal periodic sync
// - sync_soft            in   1    one-cycle software sync request
// - sync_period          in   SPW  internal sync period, clk cycles
// - sync_in              in   1    asynchronous external sync
// - tdd_sync_rst         in   1    counter resync mode (affects missed flag only)
// - cfg_burst_count      in   BCW  staged burst count
// - cfg_startup_delay    in   RW   staged startup delay
// - cfg_frame_length     in   RW   staged frame length
// - cfg_update           in   1    one-cycle pulse: capture cfg_* into staging
// - sync_missed_clr      in   1    clear sticky sync_missed
// - tdd_sync             out  1    merged one-cycle sync to counter
// - tdd_burst_count      out  BCW  committed burst count
// - tdd_startup_delay    out  RW   committed startup delay
// - tdd_frame_length     out  RW   committed frame length
// - cfg_pending          out  1    staged config not yet committed
// - sync_count           out  SPW  delivered tdd_sync pulses, wraps
// - sync_missed          out  1    sticky: sync delivered while not ARMED
// BEHAVIOUR
// - Reset: all outputs and internal state 0. A reset mid-operation discards pending config and
//   zeroes the committed config.
// - External path: 2-flop synchronizer plus 1 edge flop. ext_edge = s2 & ~s3.
//   - Edge k is the first edge sampling sync_in=1; tdd_sync is high in the cycle after edge k+2.
//   - Only rising edges count; a level held high yields one pulse.
// - Internal path: period counter cleared when tdd_enable=0, sync_int_en=0 or sync_period<2.
//   - Otherwise it counts 0..sync_period-1 and raises int_tick when count==sync_period-1, then wraps
//     to 0.
//   - First tick comes sync_period cycles after enable.
//   - A sync_period change takes effect on the next compare; if count>=new period, the count wraps
//     to 0 with no tick.
// - Soft path: sync_soft is used directly; it is not gated by the *_en inputs.
// - Merge: tdd_sync <= tdd_enable & (ext_edge&sync_ext_en | int_tick | sync_soft).
//   - Coincident sources give a single 1-cycle pulse; latency is 1 cycle from each source term.
//   - tdd_enable=0 forces tdd_sync=0 on the next cycle.
// - sync_count increments by 1 on each cycle with tdd_sync=1 and wraps at 2^SPW to 0.
//   tdd_enable does not clear it; only reset does.
// - sync_missed is set when tdd_sync=1 and tdd_cstate!=ARMED and tdd_sync_rst=0.
//   - Cleared by sync_missed_clr.
//   - Set and clear in the same cycle: set wins.
// - Config staging: cfg_update captures cfg_* into staging and sets cfg_pending. Last write wins;
//   a second update while pending overwrites staging.
// - Commit happens in a cycle with cfg_pending=1 and one of:
//   - tdd_enable=0
//   - tdd_cstate==IDLE
//   - tdd_cstate==ARMED and tdd_sync=0
//   On commit, outputs <= staging and cfg_pending <= 0. Earliest commit is 1 cycle after cfg_update.
// - cfg_update in the same cycle as a commit: commit uses the old staging, the new values are
//   captured and cfg_pending stays 1.
// - Never commit in WAITING/RUNNING, or in the ARMED cycle where tdd_sync=1.
// CONFIGURATION
// - AXI_TDD_NG_SYNC_EXT_EN defined: external synchronizer/edge path is present as above.
// - Undefined: no synchronizer flops, ext_edge=0, sync_in and sync_ext_en ignored.
//   All other behaviour is unchanged.
// TESTING
// - Ext sync: enable=1, ext_en=1, sync_in 0->1 held 20 cycles -> exactly one tdd_sync, 3 edges after
//   first sample; sync_count=1.
// - Internal: period=10, int_en=1 for 35 cycles -> tdd_sync at cycles 10, 20, 30; period=1 -> no pulses.
// - Merge: soft pulse coincident with int_tick -> single 1-cycle pulse; sync_count +1.
// - Missed: cstate=RUNNING, sync_rst=0, soft pulse -> sync_missed=1; clr+new miss same cycle -> stays 1.
// - Config commit: update (frame 100) during RUNNING -> outputs unchanged, pending=1; cstate->ARMED
//   -> outputs=100 next cycle, pending=0.
// - Reset mid-run: resetn=0 one cycle while pending and counting -> all outputs 0, pending=0,
//   period counter restarts.

Source files
------------

// File: rtl/axi_tdd_ng_sync_ctrl.sv
// axi_tdd_ng_sync_ctrl: sync sequencer and config shadow in front of the TDD-NG frame counter.
// Merges external, internal-periodic and software syncs into one tdd_sync pulse, counts
// delivered syncs, flags syncs that land outside ARMED, and holds staged timing config until
// the counter is idle or armed.
// Build option: define AXI_TDD_NG_SYNC_EXT_EN to include the external sync synchronizer/edge path.
module axi_tdd_ng_sync_ctrl #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int SYNC_PERIOD_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_tdd_enable,
  input  logic [1:0]                   i_tdd_cstate,
  input  logic                         i_sync_ext_en,
  input  logic                         i_sync_int_en,
  input  logic                         i_sync_soft,
  input  logic [SYNC_PERIOD_WIDTH-1:0] i_sync_period,
  input  logic                         i_sync_in,
  input  logic                         i_tdd_sync_rst,
  input  logic [BURST_COUNT_WIDTH-1:0] i_cfg_burst_count,
  input  logic [REGISTER_WIDTH-1:0]    i_cfg_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    i_cfg_frame_length,
  input  logic                         i_cfg_update,
  input  logic                         i_sync_missed_clr,
  output logic                         o_tdd_sync,
  output logic [BURST_COUNT_WIDTH-1:0] o_tdd_burst_count,
  output logic [REGISTER_WIDTH-1:0]    o_tdd_startup_delay,
  output logic [REGISTER_WIDTH-1:0]    o_tdd_frame_length,
  output logic                         o_cfg_pending,
  output logic [SYNC_PERIOD_WIDTH-1:0] o_sync_count,
  output logic                         o_sync_missed
);

  // Frame counter state encoding as driven by the counter block.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;

  localparam logic [SYNC_PERIOD_WIDTH-1:0] PERIOD_ONE = SYNC_PERIOD_WIDTH'(1);
  localparam logic [SYNC_PERIOD_WIDTH-1:0] PERIOD_TWO = SYNC_PERIOD_WIDTH'(2);

  logic                         w_ext_edge;
  logic                         w_int_act;
  logic                         w_int_tick;
  logic                         w_commit;
  logic [SYNC_PERIOD_WIDTH-1:0] w_period_last;

  logic                         r_tdd_sync;
  logic [SYNC_PERIOD_WIDTH-1:0] r_int_cnt;
  logic [SYNC_PERIOD_WIDTH-1:0] r_sync_count;
  logic                         r_sync_missed;
  logic                         r_cfg_pending;
  logic [BURST_COUNT_WIDTH-1:0] r_stg_burst_count;
  logic [REGISTER_WIDTH-1:0]    r_stg_startup_delay;
  logic [REGISTER_WIDTH-1:0]    r_stg_frame_length;
  logic [BURST_COUNT_WIDTH-1:0] r_tdd_burst_count;
  logic [REGISTER_WIDTH-1:0]    r_tdd_startup_delay;
  logic [REGISTER_WIDTH-1:0]    r_tdd_frame_length;

`ifdef AXI_TDD_NG_SYNC_EXT_EN
  // r_sync_sh[1:0] resynchronize sync_in, r_sync_sh[2] is the edge-detect delay.
  logic [2:0] r_sync_sh;

  // External sync synchronizer and edge-detect shift.
  always_ff @(posedge clk) begin
    if (!resetn) r_sync_sh <= '0;
    else         r_sync_sh <= {r_sync_sh[1:0], i_sync_in};
  end

  assign w_ext_edge = r_sync_sh[1] & ~r_sync_sh[2] & i_sync_ext_en;
`else
  // No external path in this build: the pins are tied off.
  logic w_unused_ext;
  assign w_unused_ext = i_sync_in ^ i_sync_ext_en;
  assign w_ext_edge   = 1'b0;
`endif

  // Internal generator runs only for periods of 2 or more; shorter periods park it at 0.
  assign w_period_last = i_sync_period - PERIOD_ONE;
  assign w_int_act     = i_tdd_enable & i_sync_int_en & (i_sync_period >= PERIOD_TWO);
  assign w_int_tick    = w_int_act & (r_int_cnt == w_period_last);

  // Period counter: wraps on the tick, and also (silently) if the period shrank below the count.
  always_ff @(posedge clk) begin
    if (!resetn || !w_int_act)         r_int_cnt <= '0;
    else if (r_int_cnt >= w_period_last) r_int_cnt <= '0;
    else                                r_int_cnt <= r_int_cnt + PERIOD_ONE;
  end

  // Merge all sources into one registered pulse; coincident sources collapse to one.
  always_ff @(posedge clk) begin
    if (!resetn) r_tdd_sync <= 1'b0;
    else         r_tdd_sync <= i_tdd_enable & (w_ext_edge | w_int_tick | i_sync_soft);
  end

  // Delivered sync counter; survives tdd_enable=0, wraps naturally.
  always_ff @(posedge clk) begin
    if (!resetn)         r_sync_count <= '0;
    else if (r_tdd_sync) r_sync_count <= r_sync_count + PERIOD_ONE;
  end

  // Sticky missed flag; a new miss beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn)
      r_sync_missed <= 1'b0;
    else if (r_tdd_sync && (i_tdd_cstate != ST_ARMED) && !i_tdd_sync_rst)
      r_sync_missed <= 1'b1;
    else if (i_sync_missed_clr)
      r_sync_missed <= 1'b0;
  end

  // Commit only while no frame is in flight: disabled, IDLE, or ARMED without a sync this cycle.
  assign w_commit = r_cfg_pending &
                    (~i_tdd_enable | (i_tdd_cstate == ST_IDLE) |
                     ((i_tdd_cstate == ST_ARMED) & ~r_tdd_sync));

  // Staging registers: last cfg_update wins; an update alongside a commit stays pending.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cfg_pending       <= 1'b0;
      r_stg_burst_count   <= '0;
      r_stg_startup_delay <= '0;
      r_stg_frame_length  <= '0;
    end else if (i_cfg_update) begin
      r_cfg_pending       <= 1'b1;
      r_stg_burst_count   <= i_cfg_burst_count;
      r_stg_startup_delay <= i_cfg_startup_delay;
      r_stg_frame_length  <= i_cfg_frame_length;
    end else if (w_commit) begin
      r_cfg_pending       <= 1'b0;
    end
  end

  // Committed config seen by the counter; loads the pre-update staging on commit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tdd_burst_count   <= '0;
      r_tdd_startup_delay <= '0;
      r_tdd_frame_length  <= '0;
    end else if (w_commit) begin
      r_tdd_burst_count   <= r_stg_burst_count;
      r_tdd_startup_delay <= r_stg_startup_delay;
      r_tdd_frame_length  <= r_stg_frame_length;
    end
  end

  assign o_tdd_sync          = r_tdd_sync;
  assign o_sync_count        = r_sync_count;
  assign o_sync_missed       = r_sync_missed;
  assign o_cfg_pending       = r_cfg_pending;
  assign o_tdd_burst_count   = r_tdd_burst_count;
  assign o_tdd_startup_delay = r_tdd_startup_delay;
  assign o_tdd_frame_length  = r_tdd_frame_length;

endmodule

// File: tb/tb_axi_tdd_ng_sync_ctrl.sv
// Scoreboard bench for axi_tdd_ng_sync_ctrl: directed scenarios then random traffic.
// The reference model predicts tick times arithmetically from the generator start cycle and
// external edges from a history of sampled sync_in values.
module tb_axi_tdd_ng_sync_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_tdd_enable, i_sync_ext_en, i_sync_int_en, i_sync_soft, i_sync_in;
  logic        i_tdd_sync_rst, i_cfg_update, i_sync_missed_clr;
  logic [1:0]  i_tdd_cstate;
  logic [31:0] i_sync_period, i_cfg_burst_count, i_cfg_startup_delay, i_cfg_frame_length;
  logic        o_tdd_sync, o_cfg_pending, o_sync_missed;
  logic [31:0] o_tdd_burst_count, o_tdd_startup_delay, o_tdd_frame_length, o_sync_count;

  axi_tdd_ng_sync_ctrl dut (
    .clk(clk), .resetn(resetn), .i_tdd_enable(i_tdd_enable), .i_tdd_cstate(i_tdd_cstate),
    .i_sync_ext_en(i_sync_ext_en), .i_sync_int_en(i_sync_int_en), .i_sync_soft(i_sync_soft),
    .i_sync_period(i_sync_period), .i_sync_in(i_sync_in), .i_tdd_sync_rst(i_tdd_sync_rst),
    .i_cfg_burst_count(i_cfg_burst_count), .i_cfg_startup_delay(i_cfg_startup_delay),
    .i_cfg_frame_length(i_cfg_frame_length), .i_cfg_update(i_cfg_update),
    .i_sync_missed_clr(i_sync_missed_clr), .o_tdd_sync(o_tdd_sync),
    .o_tdd_burst_count(o_tdd_burst_count), .o_tdd_startup_delay(o_tdd_startup_delay),
    .o_tdd_frame_length(o_tdd_frame_length), .o_cfg_pending(o_cfg_pending),
    .o_sync_count(o_sync_count), .o_sync_missed(o_sync_missed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        missed, pend;
    logic [31:0] count, burst, startup, frame;
  } stat_t;
  typedef struct {
    int          cyc;
    logic [31:0] count;
  } pulse_t;

  stat_t  sq[$];
  pulse_t pq[$];
  int     n_chk = 0;
  int     n_pass = 0;

  // Reference model state (values valid for the current cycle).
  logic        m_pulse = 0, m_missed = 0, m_pend = 0, m_act = 0;
  logic [31:0] m_count = 0;
  logic [31:0] m_stg[3] = '{0, 0, 0};
  logic [31:0] m_cfg[3] = '{0, 0, 0};
  int          m_c0 = 0;
  bit          hist[8] = '{default: 0};

  // Evaluate the model for the inputs of this cycle, queue expectations for the next, advance.
  task automatic go();
    int     n = cyc;
    int     per;
    logic   act, tick, ext, commit, nx;
    stat_t  s;
    pulse_t p;
    hist[n & 7] = i_sync_in;
    if (!resetn) begin
      nx = 0; m_missed = 0; m_pend = 0; m_act = 0; m_count = 0;
      m_stg = '{0, 0, 0}; m_cfg = '{0, 0, 0};
      hist[n & 7] = 0; hist[(n - 1) & 7] = 0; hist[(n - 2) & 7] = 0;
    end else begin
      per = int'(i_sync_period);
      act = i_tdd_enable && i_sync_int_en && per >= 2;
      if (act && !m_act) m_c0 = n;
      m_act = act;
      tick = act && ((n - m_c0) % per == per - 1);
`ifdef AXI_TDD_NG_SYNC_EXT_EN
      ext = i_sync_ext_en && hist[(n - 2) & 7] && !hist[(n - 3) & 7];
`else
      ext = 0;
`endif
      nx = i_tdd_enable && (ext || tick || i_sync_soft);
      commit = m_pend && (!i_tdd_enable || i_tdd_cstate == 2'd0 ||
                          (i_tdd_cstate == 2'd1 && !m_pulse));
      if (m_pulse && i_tdd_cstate != 2'd1 && !i_tdd_sync_rst) m_missed = 1;
      else if (i_sync_missed_clr) m_missed = 0;
      if (commit) m_cfg = m_stg;
      if (i_cfg_update) begin
        m_stg = '{i_cfg_burst_count, i_cfg_startup_delay, i_cfg_frame_length};
        m_pend = 1;
      end else if (commit) m_pend = 0;
      if (m_pulse) m_count = m_count + 1;
    end
    m_pulse = nx;
    s.cyc = n + 1; s.missed = m_missed; s.pend = m_pend; s.count = m_count;
    s.burst = m_cfg[0]; s.startup = m_cfg[1]; s.frame = m_cfg[2];
    sq.push_back(s);
    if (nx) begin
      p.cyc = n + 1; p.count = m_count;
      pq.push_back(p);
    end
    @(negedge clk);
  endtask

  // Monitor: compares the status snapshot every cycle and pops the pulse queue on each tdd_sync.
  initial begin
    stat_t  e;
    pulse_t p;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        n_chk++;
        if (e.cyc != cyc || o_sync_missed !== e.missed || o_cfg_pending !== e.pend ||
            o_sync_count !== e.count || o_tdd_burst_count !== e.burst ||
            o_tdd_startup_delay !== e.startup || o_tdd_frame_length !== e.frame)
          $display("FAIL status cyc=%0d/%0d missed=%b/%b pend=%b/%b count=%0d/%0d burst=%0h/%0h start=%0h/%0h frame=%0h/%0h (got/exp)",
                   cyc, e.cyc, o_sync_missed, e.missed, o_cfg_pending, e.pend, o_sync_count, e.count,
                   o_tdd_burst_count, e.burst, o_tdd_startup_delay, e.startup, o_tdd_frame_length, e.frame);
        else n_pass++;
      end
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        p = pq.pop_front();
        n_chk++;
        $display("FAIL missing_sync cyc=%0d got tdd_sync=0 expected 1", p.cyc);
      end
      if (o_tdd_sync === 1'b1) begin
        n_chk++;
        if (pq.size() == 0 || pq[0].cyc != cyc)
          $display("FAIL spurious_sync cyc=%0d got tdd_sync=1 expected 0", cyc);
        else begin
          p = pq.pop_front();
          if (o_sync_count !== p.count)
            $display("FAIL sync_count_at_pulse cyc=%0d got %0d expected %0d", cyc, o_sync_count, p.count);
          else n_pass++;
        end
      end
    end
  end

  initial begin
    resetn = 0; i_tdd_enable = 0; i_tdd_cstate = 2'd0; i_sync_ext_en = 0; i_sync_int_en = 0;
    i_sync_soft = 0; i_sync_period = 0; i_sync_in = 0; i_tdd_sync_rst = 0; i_cfg_update = 0;
    i_sync_missed_clr = 0; i_cfg_burst_count = 0; i_cfg_startup_delay = 0; i_cfg_frame_length = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) go();
    resetn = 1;

    // Internal periodic sync, period 10, then period 1 (no pulses).
    i_tdd_enable = 1; i_tdd_cstate = 2'd1; i_sync_period = 10; i_sync_int_en = 1;
    for (int i = 0; i < 35; i++) go();
    i_sync_int_en = 0; go();
    i_sync_period = 1; i_sync_int_en = 1;
    for (int i = 0; i < 20; i++) go();
    i_sync_int_en = 0; i_sync_period = 10; go();

    // External level held high: one pulse when the path is built in, none otherwise.
    i_sync_ext_en = 1; i_sync_in = 1;
    for (int i = 0; i < 20; i++) go();
    i_sync_in = 0;
    for (int i = 0; i < 5; i++) go();

    // Soft pulse coincident with an internal tick (period 4, tick on 4th active cycle).
    i_sync_period = 4; i_sync_int_en = 1;
    for (int i = 0; i < 3; i++) go();
    i_sync_soft = 1; go(); i_sync_soft = 0;
    for (int i = 0; i < 3; i++) go();
    i_sync_int_en = 0; go();

    // Missed sync while RUNNING, then clear coincident with a new miss.
    i_tdd_cstate = 2'd3; i_tdd_sync_rst = 0;
    i_sync_soft = 1; go(); i_sync_soft = 0;
    for (int i = 0; i < 3; i++) go();
    i_sync_soft = 1; go(); i_sync_soft = 0; i_sync_missed_clr = 1; go(); i_sync_missed_clr = 0;
    go(); go();
    i_sync_missed_clr = 1; go(); i_sync_missed_clr = 0; go();

    // Config update during RUNNING holds off until ARMED.
    i_cfg_burst_count = 3; i_cfg_startup_delay = 7; i_cfg_frame_length = 100;
    i_cfg_update = 1; go(); i_cfg_update = 0;
    for (int i = 0; i < 5; i++) go();
    i_tdd_cstate = 2'd1;
    for (int i = 0; i < 3; i++) go();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      i_tdd_enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) i_tdd_cstate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) i_sync_int_en = ~i_sync_int_en;
      if (!i_sync_int_en && $urandom_range(0, 3) == 0) i_sync_period = $urandom_range(0, 9);
      i_sync_soft = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) i_sync_in = ~i_sync_in;
      i_sync_ext_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) i_tdd_sync_rst = ~i_tdd_sync_rst;
      i_cfg_update = ($urandom_range(0, 11) == 0);
      i_cfg_burst_count = $urandom; i_cfg_startup_delay = $urandom; i_cfg_frame_length = $urandom;
      i_sync_missed_clr = ($urandom_range(0, 9) == 0);
      go();
    end

    // Reset in the middle of counting with config pending.
    i_tdd_enable = 1; i_tdd_cstate = 2'd3; i_sync_int_en = 0; i_sync_soft = 0; i_sync_in = 0;
    i_cfg_update = 0; i_sync_missed_clr = 0; go();
    i_sync_period = 6; i_sync_int_en = 1; go();
    i_cfg_frame_length = 55; i_cfg_update = 1; go(); i_cfg_update = 0;
    for (int i = 0; i < 3; i++) go();
    resetn = 0; go(); resetn = 1;
    for (int i = 0; i < 15; i++) go();
    i_sync_int_en = 0;
    for (int i = 0; i < 4; i++) go();

    if (pq.size() != 0) begin
      n_chk++;
      $display("FAIL pending_syncs got %0d outstanding expected 0", pq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
